// File: rtl/forward_ctrl.sv
// forward_ctrl
//
// Forwarding and load-use hazard controller for a 5-stage pipeline.
//
// The block keeps shadow copies of the destination and control fields of the
// ID/EX, EX/MEM and MEM/WB pipeline registers. These copies advance on every
// rising edge, in lock-step with the datapath. From them it derives the EX
// operand-select codes and the one-cycle load-use stall.
//
// Ports
//   clk, rst_n                 pipeline clock (rising edge), async active-low reset
//   id_valid                   a real instruction occupies ID
//   id_rs, id_rt               ID source register indices
//   id_rs_used, id_rt_used     the corresponding source is actually read
//   id_rd                      ID destination register index
//   id_reg_write, id_mem_read  ID instruction writes the RF / is a load
//   ex_flush                   taken branch/jump in EX: squash the ID instruction
//   Forward1A, Forward1B       EX operand select
//                              (2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 RF)
//   stall                      hold PC and IF/ID; ID/EX receives a bubble
//   stall_cnt                  saturating count of stall cycles since reset
module forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_flush,
  output logic [1:0]       Forward1A,
  output logic [1:0]       Forward1B,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // ID/EX shadow
  logic [REG_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_W-1:0] idex_rd_q, idex_rd_d;
  logic             idex_rw_q, idex_rw_d;
  logic             idex_mr_q, idex_mr_d;
  // EX/MEM shadow
  logic [REG_W-1:0] exmem_rd_q;
  logic             exmem_rw_q;
  logic             exmem_mr_q;
  // MEM/WB shadow
  logic [REG_W-1:0] memwb_rd_q;
  logic             memwb_rw_q;
  // Stall counter
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic stall_c;
  logic bubble;

  // Hazard detection and next-state for ID/EX and the counter.
  always_comb begin
    load_use = idex_mr_q && (idex_rd_q != '0) &&
               ((id_rs_used && (id_rs == idex_rd_q)) ||
                (id_rt_used && (id_rt == idex_rd_q)));
    // A flush squashes the consumer, so there is nothing left to stall for.
    stall_c  = id_valid && !ex_flush && load_use;
    bubble   = stall_c || ex_flush || !id_valid;

    idex_rs_d = '0;
    idex_rt_d = '0;
    idex_rd_d = '0;
    idex_rw_d = 1'b0;
    idex_mr_d = 1'b0;
    if (!bubble) begin
      // Unused sources are stored as r0 so they can never match a producer.
      idex_rs_d = id_rs_used ? id_rs : '0;
      idex_rt_d = id_rt_used ? id_rt : '0;
      idex_rd_d = id_rd;
      idex_rw_d = id_reg_write;
      idex_mr_d = id_mem_read;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_rs_q   <= '0;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
      idex_rw_q   <= 1'b0;
      idex_mr_q   <= 1'b0;
      exmem_rd_q  <= '0;
      exmem_rw_q  <= 1'b0;
      exmem_mr_q  <= 1'b0;
      memwb_rd_q  <= '0;
      memwb_rw_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      memwb_rd_q  <= exmem_rd_q;
      memwb_rw_q  <= exmem_rw_q;
      exmem_rd_q  <= idex_rd_q;
      exmem_rw_q  <= idex_rw_q;
      exmem_mr_q  <= idex_mr_q;
      idex_rs_q   <= idex_rs_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
      idex_rw_q   <= idex_rw_d;
      idex_mr_q   <= idex_mr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Operand selects: the younger producer (EX/MEM) takes priority over MEM/WB.
  // r0 is never forwarded.
  logic exmem_hit_a, exmem_hit_b, memwb_hit_a, memwb_hit_b;

  assign exmem_hit_a = exmem_rw_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rs_q);
  assign exmem_hit_b = exmem_rw_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rt_q);
  assign memwb_hit_a = memwb_rw_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rs_q);
  assign memwb_hit_b = memwb_rw_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rt_q);

  assign Forward1A = exmem_hit_a ? 2'b10 : (memwb_hit_a ? 2'b01 : 2'b00);
  assign Forward1B = exmem_hit_b ? 2'b10 : (memwb_hit_b ? 2'b01 : 2'b00);
  assign stall     = stall_c;
  assign stall_cnt = stall_cnt_q;

  // The load-use stall guarantees that a load in EX/MEM never has its consumer
  // in ID/EX. If it did, the 2'b10 select would pick up an unresolved load.
  a_no_load_in_exmem_to_consumer : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(exmem_mr_q && (exmem_rd_q != '0) &&
        ((exmem_rd_q == idex_rs_q) || (exmem_rd_q == idex_rt_q)))
  );

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 8;   // narrow counter so saturation is reachable quickly
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             rs_used;
    logic             rt_used;
    logic             reg_write;
    logic             mem_read;
    logic             flush;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, ex_flush;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [1:0]       Forward1A, Forward1B;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_flush     (ex_flush),
    .Forward1A    (Forward1A),
    .Forward1B    (Forward1B),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a history of what entered EX, youngest first.
  // inflight[0] is in EX, inflight[1] one stage ahead, inflight[2] two ahead.
  instr_t inflight[$];
  int     stall_total;

  task automatic model_reset();
    inflight.delete();
    for (int i = 0; i < 3; i++) inflight.push_back('0);
    stall_total = 0;
  endtask

  // Distance of the nearest older register-writing instruction producing src.
  function automatic logic [1:0] model_fwd(input logic [REG_W-1:0] src, input logic used);
    if (!used || src == 0) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      if (inflight[d].reg_write && inflight[d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall(input instr_t in);
    instr_t ld;
    ld = inflight[0];
    if (!in.valid || in.flush) return 1'b0;
    if (!ld.mem_read || ld.rd == 0) return 1'b0;
    return (in.rs_used && in.rs == ld.rd) || (in.rt_used && in.rt == ld.rd);
  endfunction

  // ---------------- driver ----------------
  logic [1:0]       obs_fa, obs_fb;
  logic             obs_stall;
  logic [CNT_W-1:0] obs_cnt;

  function automatic instr_t mk(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                                input logic rs_u, input logic [REG_W-1:0] rt,
                                input logic rt_u, input logic rw, input logic mr);
    instr_t t;
    t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs = rs; t.rs_used = rs_u; t.rt = rt; t.rt_used = rt_u;
    t.reg_write = rw; t.mem_read = mr;
    return t;
  endfunction

  function automatic instr_t alu(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt);
    return mk(rd, rs, 1'b1, rt, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic instr_t lw(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    return mk(rd, rs, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
  endfunction

  task automatic drive(input instr_t in);
    id_valid     = in.valid;
    id_rs        = in.rs;
    id_rt        = in.rt;
    id_rs_used   = in.rs_used;
    id_rt_used   = in.rt_used;
    id_rd        = in.rd;
    id_reg_write = in.reg_write;
    id_mem_read  = in.mem_read;
    ex_flush     = in.flush;
  endtask

  // One pipeline cycle with `in` sitting in ID. Called just after a rising edge.
  task automatic run_cycle(input instr_t in);
    logic   exp_stall;
    instr_t ex;
    drive(in);
    @(negedge clk);
    ex        = inflight[0];
    exp_stall = model_stall(in);
    obs_fa    = Forward1A;
    obs_fb    = Forward1B;
    obs_stall = stall;
    obs_cnt   = stall_cnt;
    check("cyc_fa",    32'(obs_fa),    32'(model_fwd(ex.rs, ex.rs_used)));
    check("cyc_fb",    32'(obs_fb),    32'(model_fwd(ex.rt, ex.rt_used)));
    check("cyc_stall", 32'(obs_stall), 32'(exp_stall));
    check("cyc_cnt",   32'(obs_cnt),   32'((stall_total > CNT_MAX) ? CNT_MAX : stall_total));
    @(posedge clk);
    if (exp_stall) stall_total++;
    inflight.push_front((exp_stall || !in.valid || in.flush) ? instr_t'('0) : in);
    void'(inflight.pop_back());
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) run_cycle('0);
  endtask

  // ---------------- stimulus ----------------
  int     cnt_before;
  instr_t rnd, ldr;

  initial begin
    rst_n = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_fa",    32'(Forward1A), 32'd0);
    check("rst_fb",    32'(Forward1B), 32'd0);
    check("rst_stall", 32'(stall),     32'd0);
    check("rst_cnt",   32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back ALU dependency
    run_cycle(alu(5'd3, 5'd1, 5'd2));
    run_cycle(alu(5'd4, 5'd3, 5'd5));
    run_cycle('0);
    check("b2b_fa",    32'(obs_fa),    32'h2);
    check("b2b_fb",    32'(obs_fb),    32'h0);
    check("b2b_stall", 32'(obs_stall), 32'h0);
    drain();

    // Distance-2 dependency, then both stages writing r3
    run_cycle(alu(5'd3, 5'd1, 5'd2));
    run_cycle(alu(5'd10, 5'd11, 5'd12));
    run_cycle(alu(5'd6, 5'd7, 5'd3));
    run_cycle('0);
    check("d2_fb", 32'(obs_fb), 32'h1);
    run_cycle(alu(5'd3, 5'd1, 5'd2));
    run_cycle(alu(5'd3, 5'd1, 5'd2));
    run_cycle(alu(5'd6, 5'd7, 5'd3));
    run_cycle('0);
    check("d2_both_fb", 32'(obs_fb), 32'h2);
    drain();

    // Load-use
    cnt_before = stall_total;
    run_cycle(lw(5'd8, 5'd1));
    run_cycle(alu(5'd9, 5'd8, 5'd8));
    check("lu_stall1", 32'(obs_stall), 32'h1);
    check("lu_cnt0",   32'(obs_cnt),   32'(cnt_before));
    run_cycle(alu(5'd9, 5'd8, 5'd8));          // held in ID; bubble in ID/EX
    check("lu_stall2",  32'(obs_stall), 32'h0);
    check("lu_bub_fa",  32'(obs_fa),    32'h0);
    check("lu_cnt1",    32'(obs_cnt),   32'(cnt_before + 1));
    run_cycle('0);
    check("lu_fa", 32'(obs_fa), 32'h1);
    check("lu_fb", 32'(obs_fb), 32'h1);
    drain();

    // r0 and unused sources
    run_cycle(lw(5'd0, 5'd1));
    run_cycle(alu(5'd1, 5'd0, 5'd0));
    check("r0_stall", 32'(obs_stall), 32'h0);
    run_cycle('0);
    check("r0_fa", 32'(obs_fa), 32'h0);
    check("r0_fb", 32'(obs_fb), 32'h0);
    run_cycle(lw(5'd5, 5'd1));
    run_cycle(mk(5'd2, 5'd6, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0));
    check("unused_stall", 32'(obs_stall), 32'h0);
    run_cycle('0);
    check("unused_fa", 32'(obs_fa), 32'h0);
    check("unused_fb", 32'(obs_fb), 32'h0);
    drain();

    // Flush over stall
    cnt_before = stall_total;
    run_cycle(lw(5'd8, 5'd1));
    rnd = alu(5'd9, 5'd8, 5'd8);
    rnd.flush = 1'b1;
    run_cycle(rnd);
    check("fl_stall", 32'(obs_stall), 32'h0);
    check("fl_cnt",   32'(obs_cnt),   32'(cnt_before));
    run_cycle(alu(5'd10, 5'd9, 5'd0));
    run_cycle('0);
    check("fl_bubble_fa", 32'(obs_fa), 32'h0);
    drain();

    // Reset mid-stall
    run_cycle(alu(5'd1, 5'd2, 5'd3));
    run_cycle(lw(5'd8, 5'd1));
    drive(alu(5'd9, 5'd8, 5'd8));
    #2;
    check("pre_rst_stall", 32'(stall),     32'h1);
    check("pre_rst_fa",    32'(Forward1A), 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall),     32'h0);
    check("mid_rst_cnt",   32'(stall_cnt), 32'h0);
    check("mid_rst_fa",    32'(Forward1A), 32'h0);
    check("mid_rst_fb",    32'(Forward1B), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Saturation: a self-dependent load stalls every other cycle
    ldr = lw(5'd8, 5'd8);
    run_cycle(ldr);
    for (int i = 0; i < 2 * (CNT_MAX + 4); i++) run_cycle(ldr);
    run_cycle('0);
    check("sat_total", 32'(stall_total), 32'(CNT_MAX + 4));
    check("sat_cnt",   32'(obs_cnt),     32'(CNT_MAX));
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rnd           = '0;
      rnd.valid     = ($urandom_range(0, 9) != 0);
      rnd.rs        = REG_W'($urandom_range(0, 7));
      rnd.rt        = REG_W'($urandom_range(0, 7));
      rnd.rd        = REG_W'($urandom_range(0, 7));
      rnd.rs_used   = 1'($urandom_range(0, 1));
      rnd.rt_used   = 1'($urandom_range(0, 1));
      rnd.mem_read  = ($urandom_range(0, 3) == 0);
      rnd.reg_write = rnd.mem_read | 1'($urandom_range(0, 1));
      rnd.flush     = ($urandom_range(0, 15) == 0);
      run_cycle(rnd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
